// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard for an in-order five-stage core.
// Tracks pending register writers, the single outstanding load and the
// multiply/divide unit. It flags decode-stage stalls for load-use and HI/LO
// hazards, and exposes per-source busy bits for the forwarding unit.
module hazard_scoreboard (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    input  logic       ID_rs_ren,
    input  logic       ID_rt_ren,
    input  logic       ID_hilo_ren,
    input  logic       ID_is_md,
    input  logic       issue_fire,
    input  logic       issue_wen,
    input  logic [4:0] issue_wdest,
    input  logic       issue_is_load,
    input  logic       issue_is_mult,
    input  logic       issue_is_div,
    input  logic       wb_fire,
    input  logic       wb_wen,
    input  logic [4:0] wb_wdest,
    input  logic       ld_data_ok,
    input  logic       flush,
    output logic       ID_stall,
    output logic       rs_busy,
    output logic       rt_busy,
    output logic       hilo_busy,
    output logic [1:0] inflight,
    output logic       err
);

    localparam logic [5:0] MULT_CYCLES = 6'd2;
    localparam logic [5:0] DIV_CYCLES  = 6'd33;

    // Pending-writer count per architectural register. Entry 0 is never
    // written, so $0 always reads as idle.
    logic [1:0] cnt [0:31];
    logic       ld_valid;
    logic [4:0] ld_dest;
    logic [5:0] md_cnt;

    logic       inc_en;
    logic       dec_en;
    logic       same_reg;
    logic       cnt_ovf;
    logic       cnt_unf;
    logic       infl_ovf;
    logic       infl_unf;
    logic       ld_set;
    logic       ld_err;
    logic       err_set;
    logic [1:0] rs_cnt;
    logic [1:0] rt_cnt;
    logic       ld_hit;

    // Qualified increment/decrement events; writes to $0 are ignored.
    assign inc_en   = issue_fire & issue_wen & (issue_wdest != 5'd0);
    assign dec_en   = wb_fire & wb_wen & (wb_wdest != 5'd0);
    // An issue and a retire to the same register cancel each other out.
    assign same_reg = inc_en & dec_en & (issue_wdest == wb_wdest);

    assign cnt_ovf  = inc_en & ~same_reg & (cnt[issue_wdest] == 2'd3);
    assign cnt_unf  = dec_en & ~same_reg & (cnt[wb_wdest] == 2'd0);
    assign infl_ovf = issue_fire & ~wb_fire & (inflight == 2'd3);
    assign infl_unf = wb_fire & (inflight == 2'd0);

    assign ld_set   = inc_en & issue_is_load;
    assign ld_err   = ld_set & ld_valid & ~ld_data_ok;

    // A flushed cycle's issue/retire never happened, so it cannot raise err.
    assign err_set  = ~flush & (cnt_ovf | cnt_unf | infl_ovf | infl_unf | ld_err);

    // Per-register pending counts; saturate instead of wrapping on misuse.
    // NOTE: every flop in this array is reset explicitly -- a stale count left
    // over from before reset would make a register look busy forever.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) cnt[i] <= 2'd0;
        end else if (flush) begin
            for (int i = 0; i < 32; i++) cnt[i] <= 2'd0;
        end else begin
            // NOTE: non-blocking updates so both ports see the pre-edge counts
            // and the two writes below never depend on statement order.
            if (inc_en && !same_reg && !cnt_ovf)
                cnt[issue_wdest] <= cnt[issue_wdest] + 2'd1;
            if (dec_en && !same_reg && !cnt_unf)
                cnt[wb_wdest] <= cnt[wb_wdest] - 2'd1;
        end
    end

    // Number of issued instructions not yet retired, saturating at 0 and 3.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight <= 2'd0;
        end else if (flush) begin
            inflight <= 2'd0;
        end else if (issue_fire && !wb_fire && !infl_ovf) begin
            inflight <= inflight + 2'd1;
        end else if (wb_fire && !issue_fire && !infl_unf) begin
            inflight <= inflight - 2'd1;
        end
    end

    // Single outstanding load; a new load issue wins over a data return.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_valid <= 1'b0;
            ld_dest  <= 5'd0;
        end else if (flush) begin
            ld_valid <= 1'b0;
        end else if (ld_set) begin
            ld_valid <= 1'b1;
            ld_dest  <= issue_wdest;
        end else if (ld_data_ok) begin
            ld_valid <= 1'b0;
        end
    end

    // Multiply/divide busy countdown; a new operation reloads the counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_cnt <= 6'd0;
        end else if (flush) begin
            md_cnt <= 6'd0;
        end else if (issue_fire && issue_is_div) begin
            md_cnt <= DIV_CYCLES;
        end else if (issue_fire && issue_is_mult) begin
            md_cnt <= MULT_CYCLES;
        end else if (md_cnt != 6'd0) begin
            md_cnt <= md_cnt - 6'd1;
        end
    end

    // Sticky protocol-error flag; only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (err_set) begin
            err <= 1'b1;
        end
    end

    // Source busy lookup for forwarding; $0 is hard-wired idle.
    assign rs_cnt    = (ID_rs == 5'd0) ? 2'd0 : cnt[ID_rs];
    assign rt_cnt    = (ID_rt == 5'd0) ? 2'd0 : cnt[ID_rt];
    assign rs_busy   = ID_rs_ren & (rs_cnt != 2'd0);
    assign rt_busy   = ID_rt_ren & (rt_cnt != 2'd0);

    assign hilo_busy = (md_cnt != 6'd0);

    // Only load results and HI/LO stall decode; ALU results are forwarded.
    assign ld_hit    = ld_valid & ((ID_rs_ren & (ID_rs == ld_dest)) |
                                   (ID_rt_ren & (ID_rt == ld_dest)));
    assign ID_stall  = ld_hit | (hilo_busy & (ID_hilo_ren | ID_is_md));

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard. The driver applies one vector per
// cycle and queues the outputs expected for that cycle; a monitor samples
// the DUT on the falling edge and compares against the queue head.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] ID_rs, ID_rt;
    logic       ID_rs_ren, ID_rt_ren, ID_hilo_ren, ID_is_md;
    logic       issue_fire, issue_wen, issue_is_load, issue_is_mult, issue_is_div;
    logic [4:0] issue_wdest;
    logic       wb_fire, wb_wen;
    logic [4:0] wb_wdest;
    logic       ld_data_ok, flush;
    logic       ID_stall, rs_busy, rt_busy, hilo_busy, err;
    logic [1:0] inflight;

    typedef struct {
        string      name;
        logic [6:0] v;   // {stall, rs_busy, rt_busy, hilo_busy, inflight, err}
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    hazard_scoreboard dut (
        .clk           (clk),
        .reset         (reset),
        .ID_rs         (ID_rs),
        .ID_rt         (ID_rt),
        .ID_rs_ren     (ID_rs_ren),
        .ID_rt_ren     (ID_rt_ren),
        .ID_hilo_ren   (ID_hilo_ren),
        .ID_is_md      (ID_is_md),
        .issue_fire    (issue_fire),
        .issue_wen     (issue_wen),
        .issue_wdest   (issue_wdest),
        .issue_is_load (issue_is_load),
        .issue_is_mult (issue_is_mult),
        .issue_is_div  (issue_is_div),
        .wb_fire       (wb_fire),
        .wb_wen        (wb_wen),
        .wb_wdest      (wb_wdest),
        .ld_data_ok    (ld_data_ok),
        .flush         (flush),
        .ID_stall      (ID_stall),
        .rs_busy       (rs_busy),
        .rt_busy       (rt_busy),
        .hilo_busy     (hilo_busy),
        .inflight      (inflight),
        .err           (err)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] mk(input bit s, input bit rs, input bit rt,
                                      input bit h, input logic [1:0] infl, input bit e);
        return {s, rs, rt, h, infl, e};
    endfunction

    task automatic clear_in();
        ID_rs = 5'd0; ID_rt = 5'd0; ID_rs_ren = 1'b0; ID_rt_ren = 1'b0;
        ID_hilo_ren = 1'b0; ID_is_md = 1'b0;
        issue_fire = 1'b0; issue_wen = 1'b0; issue_wdest = 5'd0;
        issue_is_load = 1'b0; issue_is_mult = 1'b0; issue_is_div = 1'b0;
        wb_fire = 1'b0; wb_wen = 1'b0; wb_wdest = 5'd0;
        ld_data_ok = 1'b0; flush = 1'b0;
    endtask

    task automatic iss(input logic [4:0] d, input bit wen, input bit ld,
                       input bit mul, input bit dv);
        issue_fire = 1'b1; issue_wen = wen; issue_wdest = d;
        issue_is_load = ld; issue_is_mult = mul; issue_is_div = dv;
    endtask

    task automatic retire(input logic [4:0] d, input bit wen);
        wb_fire = 1'b1; wb_wen = wen; wb_wdest = d;
    endtask

    task automatic id(input logic [4:0] rs, input bit rs_en,
                      input logic [4:0] rt, input bit rt_en);
        ID_rs = rs; ID_rs_ren = rs_en; ID_rt = rt; ID_rt_ren = rt_en;
    endtask

    // Queue the expectation for the current cycle, then advance to the
    // point just after the next rising edge.
    task automatic step(input string name, input logic [6:0] v);
        exp_t e;
        e.name = name;
        e.v    = v;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Reset asserted between edges, checked while held, released afterwards.
    task automatic pulse_reset(input string name, input bit hilo_rd);
        clear_in();
        ID_hilo_ren = hilo_rd;
        id(5'd8, 1'b1, 5'd10, 1'b1);
        reset = 1'b1;
        step(name, mk(0, 0, 0, 0, 2'd0, 0));
        reset = 1'b0;
    endtask

    // Monitor: one comparison per queued expectation, on the falling edge.
    initial begin
        exp_t       e;
        logic [6:0] got;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                got = {ID_stall, rs_busy, rt_busy, hilo_busy, inflight, err};
                n_vec++;
                if (got !== e.v) begin
                    n_bad++;
                    $display("FAIL %s @%0t: stall/rs/rt/hilo/infl/err got %b_%b_%b_%b_%0d_%b required %b_%b_%b_%b_%0d_%b",
                             e.name, $time, got[6], got[5], got[4], got[3], got[2:1], got[0],
                             e.v[6], e.v[5], e.v[4], e.v[3], e.v[2:1], e.v[0]);
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        clear_in();
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        // Reset state, with decode asking for everything.
        id(5'd5, 1'b1, 5'd7, 1'b1);
        ID_hilo_ren = 1'b1; ID_is_md = 1'b1;
        step("reset_state", mk(0, 0, 0, 0, 2'd0, 0));
        reset = 1'b0;

        // Load-use on rs.
        clear_in(); iss(5'd5, 1, 1, 0, 0);
        step("ld5_issue", mk(0, 0, 0, 0, 2'd0, 0));
        clear_in(); id(5'd5, 1, 5'd0, 0);
        step("ld5_use_stall", mk(1, 1, 0, 0, 2'd1, 0));
        clear_in(); id(5'd5, 1, 5'd0, 0); ld_data_ok = 1'b1;
        step("ld5_dataok_cycle", mk(1, 1, 0, 0, 2'd1, 0));
        clear_in(); id(5'd5, 1, 5'd0, 0);
        step("ld5_stall_gone", mk(0, 1, 0, 0, 2'd1, 0));
        clear_in(); id(5'd5, 1, 5'd0, 0); retire(5'd5, 1);
        step("ld5_retire", mk(0, 1, 0, 0, 2'd1, 0));
        clear_in(); id(5'd5, 1, 5'd5, 1);
        step("ld5_idle", mk(0, 0, 0, 0, 2'd0, 0));

        // Load-use on rt, read-enable gating, data return with retire.
        clear_in(); iss(5'd7, 1, 1, 0, 0); id(5'd0, 0, 5'd7, 1);
        step("ld7_issue", mk(0, 0, 0, 0, 2'd0, 0));
        clear_in(); id(5'd7, 0, 5'd7, 1);
        step("ld7_rt_stall", mk(1, 0, 1, 0, 2'd1, 0));
        clear_in(); id(5'd7, 0, 5'd7, 0); ld_data_ok = 1'b1; retire(5'd7, 1);
        step("ld7_no_ren", mk(0, 0, 0, 0, 2'd1, 0));
        clear_in(); id(5'd0, 0, 5'd7, 1);
        step("ld7_idle", mk(0, 0, 0, 0, 2'd0, 0));

        // ALU dependency: busy for forwarding but no stall.
        clear_in(); iss(5'd9, 1, 0, 0, 0);
        step("alu9_issue", mk(0, 0, 0, 0, 2'd0, 0));
        clear_in(); id(5'd9, 1, 5'd0, 0); retire(5'd9, 1);
        step("alu9_no_stall", mk(0, 1, 0, 0, 2'd1, 0));
        clear_in(); id(5'd9, 1, 5'd0, 0);
        step("alu9_idle", mk(0, 0, 0, 0, 2'd0, 0));

        // Divide: HI/LO stall for exactly 33 cycles.
        clear_in(); iss(5'd0, 0, 0, 0, 1);
        step("div_issue", mk(0, 0, 0, 0, 2'd0, 0));
        for (int k = 0; k < 33; k++) begin
            clear_in(); ID_hilo_ren = 1'b1;
            if (k == 0) retire(5'd0, 0);
            step("div_stall", (k == 0) ? mk(1, 0, 0, 1, 2'd1, 0) : mk(1, 0, 0, 1, 2'd0, 0));
        end
        clear_in(); ID_hilo_ren = 1'b1;
        step("div_done", mk(0, 0, 0, 0, 2'd0, 0));

        // Multiply: 2-cycle stall, also seen by a following mult/div.
        clear_in(); iss(5'd0, 0, 0, 1, 0); ID_is_md = 1'b1;
        step("mult_issue", mk(0, 0, 0, 0, 2'd0, 0));
        clear_in(); ID_hilo_ren = 1'b1; retire(5'd0, 0);
        step("mult_stall1", mk(1, 0, 0, 1, 2'd1, 0));
        clear_in(); ID_is_md = 1'b1;
        step("mult_stall2", mk(1, 0, 0, 1, 2'd0, 0));
        clear_in(); ID_is_md = 1'b1;
        step("mult_done", mk(0, 0, 0, 0, 2'd0, 0));

        // Triple writer to $8 and saturation on the fourth.
        clear_in(); iss(5'd8, 1, 0, 0, 0); id(5'd8, 1, 5'd0, 0);
        step("w8_first", mk(0, 0, 0, 0, 2'd0, 0));
        clear_in(); iss(5'd8, 1, 0, 0, 0); id(5'd8, 1, 5'd0, 0);
        step("w8_second", mk(0, 1, 0, 0, 2'd1, 0));
        clear_in(); iss(5'd8, 1, 0, 0, 0); id(5'd8, 1, 5'd0, 0);
        step("w8_third", mk(0, 1, 0, 0, 2'd2, 0));
        clear_in(); iss(5'd8, 1, 0, 0, 0); retire(5'd8, 1); id(5'd8, 1, 5'd0, 0);
        step("w8_issue_retire", mk(0, 1, 0, 0, 2'd3, 0));
        clear_in(); iss(5'd8, 1, 0, 0, 0); id(5'd8, 1, 5'd0, 0);
        step("w8_fourth", mk(0, 1, 0, 0, 2'd3, 0));
        clear_in(); retire(5'd8, 1); id(5'd8, 1, 5'd0, 0);
        step("w8_err_set", mk(0, 1, 0, 0, 2'd3, 1));
        clear_in(); retire(5'd8, 1); id(5'd8, 1, 5'd0, 0);
        step("w8_cnt2", mk(0, 1, 0, 0, 2'd2, 1));
        clear_in(); retire(5'd8, 1); id(5'd8, 1, 5'd0, 0);
        step("w8_cnt1", mk(0, 1, 0, 0, 2'd1, 1));
        clear_in(); id(5'd8, 1, 5'd0, 0);
        step("w8_cnt0", mk(0, 0, 0, 0, 2'd0, 1));
        pulse_reset("err_reset", 1'b0);

        // Retire with nothing in flight.
        clear_in(); retire(5'd3, 1);
        step("underflow_cycle", mk(0, 0, 0, 0, 2'd0, 0));
        clear_in();
        step("underflow_err", mk(0, 0, 0, 0, 2'd0, 1));
        pulse_reset("underflow_reset", 1'b0);

        // Register zero is never tracked.
        clear_in(); iss(5'd0, 1, 0, 0, 0); id(5'd0, 1, 5'd0, 1);
        step("r0_issue", mk(0, 0, 0, 0, 2'd0, 0));
        clear_in(); id(5'd0, 1, 5'd0, 1); retire(5'd0, 1);
        step("r0_not_busy", mk(0, 0, 0, 0, 2'd1, 0));
        clear_in(); id(5'd0, 1, 5'd0, 1);
        step("r0_idle", mk(0, 0, 0, 0, 2'd0, 0));

        // Flush with a load, a divide (md_cnt=20) and two in flight.
        clear_in(); iss(5'd10, 1, 1, 0, 0);
        step("fl_load", mk(0, 0, 0, 0, 2'd0, 0));
        clear_in(); iss(5'd0, 0, 0, 0, 1);
        step("fl_div", mk(0, 0, 0, 0, 2'd1, 0));
        for (int k = 0; k < 13; k++) begin
            clear_in(); id(5'd10, 1, 5'd0, 0);
            step("fl_wait", mk(1, 1, 0, 1, 2'd2, 0));
        end
        clear_in(); id(5'd10, 1, 5'd0, 0); ID_hilo_ren = 1'b1;
        iss(5'd11, 1, 1, 0, 0); flush = 1'b1;
        step("fl_flush", mk(1, 1, 0, 1, 2'd2, 0));
        clear_in(); id(5'd10, 1, 5'd11, 1); ID_hilo_ren = 1'b1;
        step("fl_cleared", mk(0, 0, 0, 0, 2'd0, 0));

        // Asynchronous reset part-way through a divide (md_cnt=10).
        clear_in(); iss(5'd0, 0, 0, 0, 1);
        step("ar_div", mk(0, 0, 0, 0, 2'd0, 0));
        for (int k = 0; k < 23; k++) begin
            clear_in(); ID_hilo_ren = 1'b1;
            step("ar_div_busy", mk(1, 0, 0, 1, 2'd1, 0));
        end
        pulse_reset("ar_reset_held", 1'b1);
        clear_in(); ID_hilo_ren = 1'b1; ID_is_md = 1'b1;
        step("ar_after1", mk(0, 0, 0, 0, 2'd0, 0));
        clear_in(); ID_hilo_ren = 1'b1;
        step("ar_after2", mk(0, 0, 0, 0, 2'd0, 0));

        // Data return and new load in the same cycle; then a double load.
        clear_in(); iss(5'd12, 1, 1, 0, 0);
        step("nl_ld12", mk(0, 0, 0, 0, 2'd0, 0));
        clear_in(); iss(5'd13, 1, 1, 0, 0); ld_data_ok = 1'b1; id(5'd13, 1, 5'd0, 0);
        step("nl_ld13_dataok", mk(0, 0, 0, 0, 2'd1, 0));
        clear_in(); id(5'd13, 1, 5'd12, 1);
        step("nl_ld13_wins", mk(1, 1, 1, 0, 2'd2, 0));
        clear_in(); iss(5'd14, 1, 1, 0, 0);
        step("nl_double_load", mk(0, 0, 0, 0, 2'd2, 0));
        clear_in();
        step("nl_double_err", mk(0, 0, 0, 0, 2'd3, 1));

        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
